// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the input conditioning slice.
// State encoding is fixed so debug views decode the same everywhere.
package input_cond_pkg;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } cond_state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Output is the input delayed by two clock edges.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/input_debounce_edge.sv
// Synchronise, debounce and edge-detect a raw level input.
// Also keeps a wrapping count of accepted rising transitions.
module input_debounce_edge
    import input_cond_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);
    localparam bit ONE_CYCLE = (STABLE_CYCLES == 1);

    logic        s;
    cond_state_t state;
    logic [QW-1:0] q;
    logic        accept_rise;
    logic        accept_fall;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    always_comb begin
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        if (en) begin
            unique case (state)
                S_LOW:   accept_rise = s && ONE_CYCLE;
                S_CHK_H: accept_rise = s && (q == Q_LAST);
                S_HIGH:  accept_fall = !s && ONE_CYCLE;
                S_CHK_L: accept_fall = !s && (q == Q_LAST);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOW;
            q     <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= accept_rise;
            fall <= accept_fall;
            if (!en) begin
                // Freeze: abandon any qualification in progress
                q     <= '0;
                busy  <= 1'b0;
                state <= dout ? S_HIGH : S_LOW;
            end else if (accept_rise) begin
                state <= S_HIGH;
                dout  <= 1'b1;
                q     <= '0;
                busy  <= 1'b0;
            end else if (accept_fall) begin
                state <= S_LOW;
                dout  <= 1'b0;
                q     <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_LOW: begin
                        if (s) begin
                            state <= S_CHK_H;
                            q     <= QW'(1);
                            busy  <= 1'b1;
                        end
                    end
                    S_CHK_H: begin
                        if (!s) begin
                            state <= S_LOW;
                            q     <= '0;
                            busy  <= 1'b0;
                        end else begin
                            q <= q + QW'(1);
                        end
                    end
                    S_HIGH: begin
                        if (!s) begin
                            state <= S_CHK_L;
                            q     <= QW'(1);
                            busy  <= 1'b1;
                        end
                    end
                    S_CHK_L: begin
                        if (s) begin
                            state <= S_HIGH;
                            q     <= '0;
                            busy  <= 1'b0;
                        end else begin
                            q <= q + QW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Clear takes effect before a same-cycle rise is counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_cnt <= '0;
        end else if (clr_cnt) begin
            rise_cnt <= accept_rise ? CNT_W'(1) : '0;
        end else if (accept_rise) begin
            rise_cnt <= rise_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_input_debounce_edge.sv
// Directed bench for input_debounce_edge: default build and a
// single-cycle-window, 2-bit-counter build side by side.
module tb_input_debounce_edge;
    import input_cond_pkg::*;

    logic       clk;
    logic       rst;
    logic       din, en, clr_cnt;
    logic       dout, rise, fall, busy;
    logic [7:0] rise_cnt;
    logic       din2, clr2;
    logic       dout2, rise2, fall2, busy2;
    logic [1:0] cnt2;

    int n_chk;
    int n_fail;

    input_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .en       (en),
        .clr_cnt  (clr_cnt),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy),
        .rise_cnt (rise_cnt)
    );

    input_debounce_edge #(.STABLE_CYCLES(1), .CNT_W(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .din      (din2),
        .en       (1'b1),
        .clr_cnt  (clr2),
        .dout     (dout2),
        .rise     (rise2),
        .fall     (fall2),
        .busy     (busy2),
        .rise_cnt (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dout, rise, fall, busy packed for compact checks
    function automatic logic [3:0] pk(input logic d, input logic r,
                                      input logic f, input logic b);
        return {d, r, f, b};
    endfunction

    logic [1:0] exp2 [5];

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3;
        exp2[3] = 2'd0; exp2[4] = 2'd1;
        rst = 1'b1;
        din = 1'b0; en = 1'b1; clr_cnt = 1'b0;
        din2 = 1'b0; clr2 = 1'b0;
        #2;
        chk("rst_outs", 32'(pk(dout, rise, fall, busy)), 0);
        chk("rst_cnt", 32'(rise_cnt), 0);
        tick();
        tick();
        rst = 1'b0;

        // idle low
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("idle_outs", 32'(pk(dout, rise, fall, busy)), 0);
            chk("idle_cnt", 32'(rise_cnt), 0);
        end

        // clean rise: dout after E0+5, busy from E0+2
        din = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rise_outs", 32'(pk(dout, rise, fall, busy)),
                32'(pk(i >= 6, i == 6, 1'b0, i >= 3 && i <= 5)));
        end
        chk("rise_cnt1", 32'(rise_cnt), 1);

        // clean fall
        din = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("fall_outs", 32'(pk(dout, rise, fall, busy)),
                32'(pk(i < 6, 1'b0, i == 6, i >= 3 && i <= 5)));
        end
        chk("fall_cnt", 32'(rise_cnt), 1);

        // 3-cycle glitch rejected
        din = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 3) din = 1'b0;
            chk("glitch3", 32'(pk(dout, rise, fall, busy)),
                32'(pk(1'b0, 1'b0, 1'b0, i >= 3 && i <= 5)));
        end
        chk("glitch3_cnt", 32'(rise_cnt), 1);

        // 4-cycle pulse accepted, then falls 6 cycles after drop
        din = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 4) din = 1'b0;
            chk("pulse4", 32'(pk(dout, rise, fall, busy)),
                32'(pk(i >= 6 && i <= 9, i == 6, i == 10,
                       (i >= 3 && i <= 5) || (i >= 7 && i <= 9))));
        end
        chk("pulse4_cnt", 32'(rise_cnt), 2);

        // freeze mid-qualification, restart after release
        din = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 3) en = 1'b0;
            if (i == 8) en = 1'b1;
            chk("freeze", 32'(pk(dout, rise, fall, busy)),
                32'(pk(i >= 12, i == 12, 1'b0,
                       i == 3 || (i >= 9 && i <= 11))));
        end
        chk("freeze_cnt", 32'(rise_cnt), 3);

        // single-cycle window, 2-bit wrap, clear coincident with rise
        for (int r = 0; r < 5; r++) begin
            din2 = 1'b1;
            for (int i = 1; i <= 3; i++) begin
                tick();
                if (i == 2) begin
                    chk("w1_pre", 32'(dout2), 0);
                    if (r == 4) clr2 = 1'b1;
                end
            end
            chk("w1_rise", 32'(pk(dout2, rise2, fall2, busy2)),
                32'(pk(1'b1, 1'b1, 1'b0, 1'b0)));
            chk("w1_cnt", 32'(cnt2), 32'(exp2[r]));
            clr2 = 1'b0;
            din2 = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                tick();
                if (i == 3)
                    chk("w1_fall", 32'(pk(dout2, rise2, fall2, busy2)),
                        32'(pk(1'b0, 1'b0, 1'b1, 1'b0)));
            end
        end
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        chk("w1_clr", 32'(cnt2), 0);

        // async reset while qualifying a fall
        din = 1'b0;
        for (int i = 1; i <= 3; i++) tick();
        chk("chkl_pre", 32'(pk(dout, rise, fall, busy)),
            32'(pk(1'b1, 1'b0, 1'b0, 1'b1)));
        #3;
        rst = 1'b1;
        #1;
        chk("arst_outs", 32'(pk(dout, rise, fall, busy)), 0);
        chk("arst_cnt", 32'(rise_cnt), 0);
        #2;
        rst = 1'b0;
        tick();
        chk("arst_post", 32'(pk(dout, rise, fall, busy)), 0);
        chk("arst_state", 32'(dut.state), 32'(S_LOW));

        // full latency after reset release
        din = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("post_rise", 32'(pk(dout, rise, fall, busy)),
                32'(pk(i >= 6, i == 6, 1'b0, i >= 3 && i <= 5)));
        end
        chk("post_cnt", 32'(rise_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
